// File: rtl/sum_join.sv
// sum_join: N-channel valid/ready join feeding a registered adder
// with a 2-entry skid output and packet framing. Optional: SUM_JOIN_SAT_EN.
module sum_join #(
    parameter int N       = 2,
    parameter int LEN     = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N*LEN-1:0]           data_in,
    input  logic [N-1:0]               valid_in,
    output logic                       ready_out,
    output logic [LEN+$clog2(N)-1:0]   data,
    output logic                       valid,
    output logic                       last,
`ifdef SUM_JOIN_SAT_EN
    output logic                       sat,
`endif
    input  logic                       ready
);

    localparam int OW = LEN + $clog2(N);
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    logic [OW-1:0] acc;
    logic [OW-1:0] sum_n;
    logic [OW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic [CW-1:0] cnt;
    logic          beat_last;
    logic          in_fire;
    logic          out_fire;

`ifdef SUM_JOIN_SAT_EN
    localparam logic [OW-1:0] MAXV = {{(OW-LEN){1'b0}}, {LEN{1'b1}}};
    logic sum_sat;
    logic s_sat;
`endif

    // Ready only depends on skid occupancy and reset, never on valid_in/ready.
    assign ready_out = !s_valid && !rst;
    assign in_fire   = (&valid_in) && ready_out;
    assign out_fire  = valid && ready;
    assign beat_last = (cnt == CW'(PKT_LEN - 1));

    // Zero-extend and add all channels; clamp when saturation is built in.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc + {{(OW-LEN){1'b0}}, data_in[k*LEN +: LEN]};
        end
`ifdef SUM_JOIN_SAT_EN
        sum_sat = (acc > MAXV);
        sum_n   = sum_sat ? MAXV : acc;
`else
        sum_n   = acc;
`endif
    end

    // Beat position within the packet, advanced per consumed input beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (in_fire) begin
            cnt <= beat_last ? '0 : cnt + CW'(1);
        end
    end

    // Main + skid registers: skid drains first so ordering stays FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            data    <= '0;
            last    <= 1'b0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_last  <= 1'b0;
`ifdef SUM_JOIN_SAT_EN
            sat     <= 1'b0;
            s_sat   <= 1'b0;
`endif
        end else if (s_valid) begin
            if (out_fire) begin
                valid   <= 1'b1;
                data    <= s_data;
                last    <= s_last;
                s_valid <= 1'b0;
`ifdef SUM_JOIN_SAT_EN
                sat     <= s_sat;
`endif
            end
        end else if (in_fire) begin
            if (!valid || out_fire) begin
                valid <= 1'b1;
                data  <= sum_n;
                last  <= beat_last;
`ifdef SUM_JOIN_SAT_EN
                sat   <= sum_sat;
`endif
            end else begin
                s_valid <= 1'b1;
                s_data  <= sum_n;
                s_last  <= beat_last;
`ifdef SUM_JOIN_SAT_EN
                s_sat   <= sum_sat;
`endif
            end
        end else if (out_fire) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_join.sv
// tb_sum_join: directed and randomized checks of sum_join against a
// depth-2 FIFO reference model with packet position tracking.
module tb_sum_join;

    localparam int N       = 2;
    localparam int LEN     = 8;
    localparam int PKT_LEN = 4;
    localparam int OW      = LEN + $clog2(N);
    localparam int DW      = N * LEN;
    localparam int MAXS    = (1 << LEN) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic [N-1:0]  valid_in;
    logic          ready_out;
    logic [OW-1:0] data;
    logic          valid;
    logic          last;
    logic          ready;
`ifdef SUM_JOIN_SAT_EN
    logic          sat;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
        logic          s;
    } beat_t;

    beat_t q[$];
    int    m_pos;
    bit    m_fired;

    always #5 clk = ~clk;

    sum_join #(.N(N), .LEN(LEN), .PKT_LEN(PKT_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data      (data),
        .valid     (valid),
        .last      (last),
`ifdef SUM_JOIN_SAT_EN
        .sat       (sat),
`endif
        .ready     (ready)
    );

    function automatic beat_t ref_beat(logic [DW-1:0] din, int pos);
        beat_t r;
        int    s;
        s = 0;
        for (int k = 0; k < N; k++) s = s + int'(din[k*LEN +: LEN]);
        r.s = 1'b0;
`ifdef SUM_JOIN_SAT_EN
        if (s > MAXS) begin
            s   = MAXS;
            r.s = 1'b1;
        end
`endif
        r.d = OW'(s);
        r.l = (pos == PKT_LEN - 1);
        return r;
    endfunction

    // One clock: model consumes/produces at the edge, returns on negedge.
    task automatic step();
        bit inf;
        bit outf;
        @(posedge clk);
        m_fired = 1'b0;
        if (rst) begin
            q.delete();
            m_pos = 0;
        end else begin
            inf  = (&valid_in) && (q.size() < 2);
            outf = (q.size() > 0) && ready;
            if (outf) void'(q.pop_front());
            if (inf) begin
                q.push_back(ref_beat(data_in, m_pos));
                m_pos   = (m_pos + 1) % PKT_LEN;
                m_fired = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input int a, input int b, input logic [N-1:0] v);
        data_in  = {LEN'(b), LEN'(a)};
        valid_in = v;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid_in = '0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ready = 1'b1;
        drive(9, 9, 2'b11);
        step();
        step();
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL rst_ready_out got=%0b want=0", ready_out); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b want=0", valid); end
        checks++; if (data !== '0) begin failures++; $display("FAIL rst_data got=%0d want=0", data); end
        checks++; if (last !== 1'b0) begin failures++; $display("FAIL rst_last got=%0b want=0", last); end
`ifdef SUM_JOIN_SAT_EN
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL rst_sat got=%0b want=0", sat); end
`endif
        valid_in = '0;
        rst = 1'b0;
        #1;
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0b want=1", ready_out); end
    endtask

    task automatic test_stream();
        int a[5] = '{3, 10, 255, 0, 7};
        int b[5] = '{4, 20, 255, 1, 7};
        int e[5] = '{7, 30, 510, 1, 14};
        int ev;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(a[i], b[i], 2'b11);
            step();
            ev = e[i];
`ifdef SUM_JOIN_SAT_EN
            if (ev > MAXS) ev = MAXS;
`endif
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%0b want=1", i, valid); end
            checks++; if (data !== OW'(ev)) begin failures++; $display("FAIL stream_data[%0d] got=%0d want=%0d", i, data, ev); end
            checks++; if (last !== (i == 3)) begin failures++; $display("FAIL stream_last[%0d] got=%0b want=%0b", i, last, (i == 3)); end
        end
        valid_in = '0;
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b want=0", valid); end
    endtask

    task automatic test_partial();
        do_reset();
        ready = 1'b1;
        drive(1, 2, 2'b01);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL partial_valid[%0d] got=%0b want=0", i, valid); end
        end
        drive(1, 2, 2'b11);
        step();
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL partial_fire_valid got=%0b want=1", valid); end
        checks++; if (data !== OW'(3)) begin failures++; $display("FAIL partial_fire_data got=%0d want=3", data); end
        checks++; if (last !== 1'b0) begin failures++; $display("FAIL partial_fire_last got=%0b want=0", last); end
        for (int i = 1; i < 4; i++) begin
            drive(i, 0, 2'b11);
            step();
            checks++; if (last !== (i == 3)) begin failures++; $display("FAIL partial_cnt_last[%0d] got=%0b want=%0b", i, last, (i == 3)); end
        end
        valid_in = '0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        drive(1, 1, 2'b11);
        step();
        drive(2, 2, 2'b11);
        step();
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL bp_ready_out got=%0b want=0", ready_out); end
        checks++; if (data !== OW'(2)) begin failures++; $display("FAIL bp_main got=%0d want=2", data); end
        drive(3, 3, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (valid !== 1'b1 || data !== OW'(2)) begin failures++; $display("FAIL bp_stall[%0d] got=%0b/%0d want=1/2", i, valid, data); end
            checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%0b want=0", i, ready_out); end
        end
        ready = 1'b1;
        step();
        checks++; if (valid !== 1'b1 || data !== OW'(4)) begin failures++; $display("FAIL bp_out2 got=%0b/%0d want=1/4", valid, data); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL bp_ready_rise got=%0b want=1", ready_out); end
        step();
        checks++; if (valid !== 1'b1 || data !== OW'(6)) begin failures++; $display("FAIL bp_out3 got=%0b/%0d want=1/6", valid, data); end
        valid_in = '0;
        step();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b want=0", valid); end
    endtask

    task automatic test_back_to_back();
        int a;
        int b;
        int ev;
        int nvalid;
        do_reset();
        ready  = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, MAXS));
            b = int'($urandom_range(0, MAXS));
            drive(a, b, 2'b11);
            step();
            ev = a + b;
`ifdef SUM_JOIN_SAT_EN
            if (ev > MAXS) ev = MAXS;
`endif
            if (valid === 1'b1) nvalid++;
            checks++; if (data !== OW'(ev)) begin failures++; $display("FAIL b2b_data[%0d] got=%0d want=%0d", i, data, ev); end
            checks++; if (last !== (i % 4 == 3)) begin failures++; $display("FAIL b2b_last[%0d] got=%0b want=%0b", i, last, (i % 4 == 3)); end
        end
        checks++; if (nvalid != 8) begin failures++; $display("FAIL b2b_valid_count got=%0d want=8", nvalid); end
        valid_in = '0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready = 1'b0;
        drive(5, 5, 2'b11);
        step();
        drive(6, 6, 2'b11);
        step();
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL mid_full got=%0b want=0", ready_out); end
        rst = 1'b1;
        valid_in = '0;
        step();
        rst = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b want=0", valid); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b want=1", ready_out); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(i, 1, 2'b11);
            step();
            checks++; if (valid !== 1'b1 || last !== (i == 3)) begin failures++; $display("FAIL mid_last[%0d] got=%0b/%0b want=1/%0b", i, valid, last, (i == 3)); end
        end
        valid_in = '0;
        step();
    endtask

    task automatic test_sat();
        do_reset();
        ready = 1'b1;
        drive(200, 100, 2'b11);
        step();
`ifdef SUM_JOIN_SAT_EN
        checks++; if (data !== OW'(255) || sat !== 1'b1) begin failures++; $display("FAIL sat_clamp got=%0d/%0b want=255/1", data, sat); end
`else
        checks++; if (data !== OW'(300)) begin failures++; $display("FAIL sat_off got=%0d want=300", data); end
`endif
        drive(10, 20, 2'b11);
        step();
        checks++; if (data !== OW'(30)) begin failures++; $display("FAIL sat_small got=%0d want=30", data); end
`ifdef SUM_JOIN_SAT_EN
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL sat_flag got=%0b want=0", sat); end
`endif
        valid_in = '0;
        step();
    endtask

    task automatic test_random();
        do_reset();
        data_in = DW'($urandom);
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(0, 9) < 7) ? '1 : N'($urandom);
            ready    = ($urandom_range(0, 9) < 6);
            step();
            if (m_fired) data_in = DW'($urandom);
            checks++; if (valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%0b want=%0b", i, valid, (q.size() > 0)); end
            checks++; if (ready_out !== (q.size() < 2)) begin failures++; $display("FAIL rnd_ready[%0d] got=%0b want=%0b", i, ready_out, (q.size() < 2)); end
            if (q.size() > 0) begin
                checks++; if (data !== q[0].d) begin failures++; $display("FAIL rnd_data[%0d] got=%0d want=%0d", i, data, q[0].d); end
                checks++; if (last !== q[0].l) begin failures++; $display("FAIL rnd_last[%0d] got=%0b want=%0b", i, last, q[0].l); end
`ifdef SUM_JOIN_SAT_EN
                checks++; if (sat !== q[0].s) begin failures++; $display("FAIL rnd_sat[%0d] got=%0b want=%0b", i, sat, q[0].s); end
`endif
            end
        end
        valid_in = '0;
        ready    = 1'b1;
        step();
        step();
        step();
    endtask

    initial begin
        rst      = 1'b1;
        ready    = 1'b1;
        valid_in = '0;
        data_in  = '0;
        m_pos    = 0;
        m_fired  = 1'b0;
        test_reset();
        test_stream();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
